// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// FSM state encoding and the default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder cell, purely combinational.
// Ports: a, b, cin in; s (sum), cout (carry) out.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one FA, LSB first, registered carry loop.
// Ports: clk, rst (async, high), start/a/b/cin in; busy, done, sum, cout, ovf out.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_part;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_c_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic w_fa_s;
  logic w_fa_cout;

  serial_adder_fa u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .s    (w_fa_s),
    .cout (w_fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_part  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_c_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_part  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_part  <= {w_fa_s, r_part[WIDTH-1:1]};
          r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + CNT_ONE;
          // carry out of bit WIDTH-2 is the carry into the MSB
          if (r_cnt == CNT_MSB)
            r_c_msb <= w_fa_cout;
          if (r_cnt == CNT_LAST) begin
            r_sum   <= {w_fa_s, r_part[WIDTH-1:1]};
            r_cout  <= w_fa_cout;
            r_ovf   <= r_c_msb ^ w_fa_cout;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
